// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, per-channel duty registers,
// and a valid/ready command port with a shift-add position-to-duty mapper. Define SERVO_SLEW_EN for rate-limited duty changes.
module servo_pwm_multi #(
    parameter int CHANNELS   = 4,
    parameter int POS_W      = 8,
    parameter int PERIOD_CYC = 500000,
    parameter int CNT_W      = 19,
    parameter int DUTY_MIN   = 12500,
    parameter int DUTY_MAX   = 60000,
    parameter int SLEW_STEP  = 250,
    localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CHAN_W-1:0]   cmd_chan,
    input  logic [POS_W-1:0]    cmd_pos,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] busy,
    output logic                frame_tick,
    output logic                cmd_err
);

    localparam int PROD_W = CNT_W + POS_W;
    localparam int BIT_W  = (POS_W > 1) ? $clog2(POS_W) : 1;
    localparam logic [CNT_W-1:0]  MIN_D    = CNT_W'(DUTY_MIN);
    localparam logic [CNT_W-1:0]  MAX_D    = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0]  DIFF_D   = CNT_W'(DUTY_MAX - DUTY_MIN);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PERIOD_CYC - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(POS_W - 1);
    localparam logic [CHAN_W:0]   CH_LIM   = (CHAN_W + 1)'(CHANNELS);

    if (DUTY_MIN > DUTY_MAX || DUTY_MAX >= PERIOD_CYC || SLEW_STEP < 1) begin : g_param_check
        $error("servo_pwm_multi: inconsistent duty/period/slew parameters");
    end

    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg;
    logic                tick;
    logic [CHAN_W-1:0]   chan_reg;
    logic [POS_W-1:0]    pos_reg;
    logic                pos_max_reg;
    logic [BIT_W-1:0]    bit_reg;
    logic [PROD_W-1:0]   acc_reg;
    logic [PROD_W-1:0]   mcand_reg;
    logic                accept;
    logic                wr_en;
    logic                chan_bad;
    logic [CNT_W-1:0]    wr_duty;

    assign tick       = (count_reg == LAST_CNT);
    assign frame_tick = tick;
    assign chan_bad   = ({1'b0, cmd_chan} >= CH_LIM);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= tick ? '0 : count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        cmd_err    = 1'b0;
        accept     = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (chan_bad) begin
                        cmd_err = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (bit_reg == LAST_BIT) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_en      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // LSB-first shift-add: one position bit per CALC cycle, full-width product.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            chan_reg    <= '0;
            pos_reg     <= '0;
            pos_max_reg <= 1'b0;
            bit_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
        end else if (accept) begin
            chan_reg    <= cmd_chan;
            pos_reg     <= cmd_pos;
            pos_max_reg <= &cmd_pos;
            bit_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= PROD_W'(DIFF_D);
        end else if (state_reg == CALC) begin
            acc_reg   <= acc_reg + (pos_reg[0] ? mcand_reg : '0);
            pos_reg   <= pos_reg >> 1;
            mcand_reg <= mcand_reg << 1;
            bit_reg   <= bit_reg + BIT_W'(1);
        end
    end

    // Full-scale position is pinned so the top of the range is exactly DUTY_MAX.
    assign wr_duty = pos_max_reg ? MAX_D : MIN_D + acc_reg[PROD_W-1:POS_W];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [CNT_W-1:0] cur_reg;
        logic [CNT_W-1:0] tgt_reg;
        logic [CNT_W-1:0] cur_next;
        logic             pwm_reg;
        logic             busy_reg;
        logic             wr_hit;

        assign wr_hit = wr_en && (chan_reg == CHAN_W'(gi));

`ifdef SERVO_SLEW_EN
        localparam logic [CNT_W-1:0] STEP_D = CNT_W'(SLEW_STEP);
        // Differences are taken in the non-negative direction only, so no wrap.
        always_comb begin
            cur_next = tgt_reg;
            if (tgt_reg > cur_reg) begin
                if (tgt_reg - cur_reg > STEP_D) begin
                    cur_next = cur_reg + STEP_D;
                end
            end else if (cur_reg - tgt_reg > STEP_D) begin
                cur_next = cur_reg - STEP_D;
            end
        end
`else
        assign cur_next = tgt_reg;
`endif

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cur_reg  <= MIN_D;
                tgt_reg  <= MIN_D;
                pwm_reg  <= 1'b0;
                busy_reg <= 1'b0;
            end else begin
                if (tick) begin
                    cur_reg <= cur_next;
                end
                if (wr_hit) begin
                    tgt_reg <= wr_duty;
                end
                pwm_reg  <= chan_en[gi] && (count_reg < cur_reg);
                busy_reg <= (cur_reg != tgt_reg);
            end
        end

        assign pwm_out[gi] = pwm_reg;
        assign busy[gi]    = busy_reg;
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi with a small frame: random commands checked every cycle against
// a time-based model of frames, targets and command latency, plus measured high-time literals.
module tb_servo_pwm_multi;

    localparam int CH   = 5;
    localparam int PW   = 4;
    localparam int P    = 200;
    localparam int CW   = 8;
    localparam int DMIN = 20;
    localparam int DMAX = 170;
    localparam int STEP = 7;
`ifdef SERVO_SLEW_EN
    localparam int EXP_POS8  = DMIN + STEP;
    localparam int EXP_POS15 = DMIN + STEP;
    localparam int EXP_BACK  = DMIN + STEP;
`else
    localparam int EXP_POS8  = 95;
    localparam int EXP_POS15 = 170;
    localparam int EXP_BACK  = 20;
`endif

    logic          clk_in    = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_chan  = '0;
    logic [PW-1:0] cmd_pos   = '0;
    logic [CH-1:0] chan_en   = '0;
    logic          cmd_ready;
    logic [CH-1:0] pwm_out;
    logic [CH-1:0] busy;
    logic          frame_tick;
    logic          cmd_err;

    servo_pwm_multi #(
        .CHANNELS(CH), .POS_W(PW), .PERIOD_CYC(P), .CNT_W(CW),
        .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .SLEW_STEP(STEP)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_pos(cmd_pos), .chan_en(chan_en), .pwm_out(pwm_out),
        .busy(busy), .frame_tick(frame_tick), .cmd_err(cmd_err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle position in frame, per-channel current/target duty, and a command in flight.
    int            m_count;
    int            m_cur[CH];
    int            m_tgt[CH];
    int            m_wait;
    int            m_wr_chan;
    int            m_wr_val;
    logic [CH-1:0] m_pwm;
    logic [CH-1:0] m_busy;

    function automatic int duty_of(input int pos);
        if (pos == (1 << PW) - 1) return DMAX;
        return DMIN + (pos * (DMAX - DMIN)) / (1 << PW);
    endfunction

    function automatic int slew(input int cur, input int tgt);
`ifdef SERVO_SLEW_EN
        if (tgt > cur) return (cur + STEP < tgt) ? cur + STEP : tgt;
        return (cur - STEP > tgt) ? cur - STEP : tgt;
`else
        return tgt + 0 * cur;
`endif
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_wait  = 0;
        m_pwm   = '0;
        m_busy  = '0;
        for (int i = 0; i < CH; i++) begin
            m_cur[i] = DMIN;
            m_tgt[i] = DMIN;
        end
    endtask

    initial begin
        logic          s_rst;
        logic          s_valid;
        int            s_chan;
        int            s_pos;
        logic [CH-1:0] s_en;
        logic [CH-1:0] np;
        logic [CH-1:0] nb;
        int            nc[CH];
        model_reset();
        forever begin
            @(posedge clk_in);
            s_rst   = rst_n;
            s_valid = cmd_valid;
            s_chan  = int'(cmd_chan);
            s_pos   = int'(cmd_pos);
            s_en    = chan_en;
            @(negedge clk_in);
            if (!s_rst || !rst_n) begin
                model_reset();
            end else begin
                for (int i = 0; i < CH; i++) begin
                    np[i] = s_en[i] && (m_count < m_cur[i]);
                    nb[i] = (m_cur[i] != m_tgt[i]);
                    nc[i] = (m_count == P - 1) ? slew(m_cur[i], m_tgt[i]) : m_cur[i];
                end
                m_count = (m_count == P - 1) ? 0 : m_count + 1;
                if (m_wait == 0) begin
                    if (s_valid && s_chan < CH) begin
                        m_wait    = PW + 1;
                        m_wr_chan = s_chan;
                        m_wr_val  = duty_of(s_pos);
                    end
                end else begin
                    m_wait--;
                    if (m_wait == 0) m_tgt[m_wr_chan] = m_wr_val;
                end
                for (int i = 0; i < CH; i++) m_cur[i] = nc[i];
                m_pwm  = np;
                m_busy = nb;
            end
            check("pwm_out", int'(pwm_out), int'(m_pwm));
            check("busy", int'(busy), int'(m_busy));
            check("frame_tick", int'(frame_tick), int'(m_count == P - 1));
            check("cmd_ready", int'(cmd_ready), int'(m_wait == 0));
            check("cmd_err", int'(cmd_err),
                  int'(m_wait == 0 && cmd_valid && int'(cmd_chan) >= CH));
        end
    end

    task automatic step_in();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 50) begin
            step_in();
            k++;
        end
        check("wait_ready_bound", int'(cmd_ready), 1);
    endtask

    task automatic send(input int ch, input int pos);
        cmd_valid = 1'b1;
        cmd_chan  = 3'(ch);
        cmd_pos   = PW'(pos);
        step_in();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        int k = 0;
        ok = 1'b0;
        while (k < 2 * P) begin
            @(negedge clk_in);
            k++;
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // High cycles of one channel over the full frame that starts after the next frame_tick.
    task automatic measure(input int ch, output int hi);
        bit ok;
        wait_tick(ok);
        if (!ok) check("tick_timeout", int'(frame_tick), 1);
        @(negedge clk_in);
        hi = 0;
        repeat (P) begin
            @(negedge clk_in);
            hi += int'(pwm_out[ch]);
        end
    endtask

    initial begin
        int hi;
        int k;
        bit ok;
        chan_en = '1;
        repeat (3) step_in();
        rst_n = 1'b1;

        wait_tick(ok);
        k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while (!frame_tick && k < 2 * P);
        check("frame_period", k, P);
        measure(0, hi);
        check("ch0_idle_high", hi, DMIN);
        measure(4, hi);
        check("ch4_idle_high", hi, DMIN);

        step_in();
        wait_ready();
        send(1, 8);
        k = 0;
        while (k < 50) begin
            @(negedge clk_in);
            if (cmd_ready) break;
            k++;
        end
        check("ready_low_cycles", k, PW + 1);
        measure(1, hi);
        check("ch1_pos8_high", hi, EXP_POS8);
        measure(0, hi);
        check("ch0_unchanged_high", hi, DMIN);

        step_in();
        wait_ready();
        send(2, 15);
        wait_ready();
        measure(2, hi);
        check("ch2_pos15_high", hi, EXP_POS15);
        step_in();
        send(2, 0);
        wait_ready();
        measure(2, hi);
        check("ch2_pos0_high", hi, EXP_BACK);

        step_in();
        wait_ready();
        cmd_valid = 1'b1;
        cmd_chan  = 3'd5;
        cmd_pos   = 4'd9;
        @(negedge clk_in);
        check("cmd_err_pulse", int'(cmd_err), 1);
        check("ready_on_err", int'(cmd_ready), 1);
        step_in();
        cmd_valid = 1'b0;
        @(negedge clk_in);
        check("cmd_err_clear", int'(cmd_err), 0);
        check("ready_after_err", int'(cmd_ready), 1);

        repeat (4000) begin
            step_in();
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_chan  = 3'($urandom_range(0, 7));
            cmd_pos   = PW'($urandom);
            if ($urandom_range(0, 99) == 0) chan_en = CH'($urandom);
        end
        cmd_valid = 1'b0;

        chan_en = '1;
        step_in();
        wait_ready();
        wait_tick(ok);
        if (!ok) check("tick_timeout_rst", int'(frame_tick), 1);
        step_in();
        send(3, 15);
        step_in();
        @(posedge clk_in);
        #3;
        check("pwm_before_rst", int'(pwm_out[0]), 1);
        rst_n = 1'b0;
        #1;
        check("pwm_async_rst", int'(pwm_out), 0);
        check("ready_async_rst", int'(cmd_ready), 1);
        check("busy_async_rst", int'(busy), 0);
        repeat (2) step_in();
        rst_n = 1'b1;
        measure(3, hi);
        check("ch3_after_rst_high", hi, DMIN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(50000 * 10);
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
